// File: rtl/uart_rom_streamer.sv
// rtl/uart_rom_streamer.sv - UART program-image receiver driving the ROM-loader handshake
module uart_rom_streamer #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  uart_rx,
    output logic                  rom_loader_reset,
    output logic                  rom_loader_load,
    output logic [DATA_WIDTH-1:0] rom_loader_data,
    input  logic                  rom_loader_ack,
    input  logic                  rom_loader_load_received,
    output logic                  done_loading,
    output logic                  busy,
    output logic [15:0]           words_loaded,
    output logic                  overrun_error,
    output logic                  framing_error
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET_REQ, S_RESET_REL, S_RX_COUNT,
        S_RX_WORD, S_LOAD_REQ, S_LOAD_REL, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic [1:0]        r_rx_sync;
    logic              r_rx_prev, r_rx_busy;
    logic [CW-1:0]     r_rx_cnt;
    logic [3:0]        r_rx_bit;
    logic [7:0]        r_rx_shift, r_byte;
    logic              r_byte_valid, r_stop_low;
    logic              r_phase, r_pending;
    logic [7:0]        r_hi;
    logic [15:0]       r_word, r_count;
    logic              w_rx, w_rx_fall, w_rx_en, w_consume, w_inc, w_start;

    // Asynchronous assert, synchronous release of the internal reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n   = r_rst_sync[1];

    assign w_rx      = r_rx_sync[1];
    assign w_rx_fall = r_rx_prev & ~w_rx;
    assign w_rx_en   = (r_state == S_RX_COUNT) || (r_state == S_RX_WORD) ||
                       (r_state == S_LOAD_REQ) || (r_state == S_LOAD_REL);

    // Bit index 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_sync    <= 2'b11;
            r_rx_prev    <= 1'b1;
            r_rx_busy    <= 1'b0;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_stop_low   <= 1'b0;
        end else begin
            r_rx_sync    <= {r_rx_sync[0], uart_rx};
            r_rx_prev    <= w_rx;
            r_byte_valid <= 1'b0;
            r_stop_low   <= 1'b0;
            if (!r_rx_busy) begin
                if (w_rx_fall) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= CW'(CLKS_PER_BIT / 2 - 1);
                    r_rx_bit  <= '0;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - CW'(1);
            end else begin
                r_rx_cnt <= CW'(CLKS_PER_BIT - 1);
                r_rx_bit <= r_rx_bit + 4'd1;
                if (r_rx_bit == 4'd0) begin
                    if (w_rx) r_rx_busy <= 1'b0;
                end else if (r_rx_bit <= 4'd8) begin
                    r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                end else begin
                    r_rx_busy <= 1'b0;
                    if (w_rx) begin
                        r_byte       <= r_rx_shift;
                        r_byte_valid <= 1'b1;
                    end else begin
                        r_stop_low   <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_consume = 1'b0;
        w_inc     = 1'b0;
        w_start   = 1'b0;
        case (r_state)
            S_IDLE:      if (run) begin w_next = S_RESET_REQ; w_start = 1'b1; end
            S_RESET_REQ: if (rom_loader_ack) w_next = S_RESET_REL;
            S_RESET_REL: if (!rom_loader_ack) w_next = S_RX_COUNT;
            S_RX_COUNT:  if (r_pending) begin
                             w_consume = 1'b1;
                             w_next    = (r_word == 16'd0) ? S_DONE : S_RX_WORD;
                         end
            S_RX_WORD:   if (r_pending) begin w_consume = 1'b1; w_next = S_LOAD_REQ; end
            S_LOAD_REQ:  if (rom_loader_load_received) w_next = S_LOAD_REL;
            S_LOAD_REL:  if (!rom_loader_load_received) begin
                             w_inc  = 1'b1;
                             w_next = (words_loaded + 16'd1 == r_count) ? S_DONE : S_RX_WORD;
                         end
            S_DONE:      if (!run) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they never glitch or overlap.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state          <= S_IDLE;
            rom_loader_reset <= 1'b0;
            rom_loader_load  <= 1'b0;
            rom_loader_data  <= '0;
            done_loading     <= 1'b0;
            busy             <= 1'b0;
            words_loaded     <= '0;
            overrun_error    <= 1'b0;
            framing_error    <= 1'b0;
            r_phase          <= 1'b0;
            r_pending        <= 1'b0;
            r_hi             <= '0;
            r_word           <= '0;
            r_count          <= '0;
        end else begin
            r_state          <= w_next;
            rom_loader_reset <= (w_next == S_RESET_REQ);
            rom_loader_load  <= (w_next == S_LOAD_REQ);
            done_loading     <= (w_next == S_DONE);
            busy             <= (w_next != S_IDLE) && (w_next != S_DONE);
            if (w_start) begin
                words_loaded  <= '0;
                overrun_error <= 1'b0;
                framing_error <= 1'b0;
            end
            if (w_inc) words_loaded <= words_loaded + 16'd1;
            if (w_consume && r_state == S_RX_COUNT) r_count <= r_word;
            if (w_consume && r_state == S_RX_WORD)  rom_loader_data <= DATA_WIDTH'(r_word);
            if (r_stop_low && w_rx_en) framing_error <= 1'b1;
            if (w_consume) r_pending <= 1'b0;
            if (r_byte_valid && w_rx_en) begin
                if (!r_phase) begin
                    r_hi    <= r_byte;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (r_pending && !w_consume) begin
                        overrun_error <= 1'b1;
                    end else begin
                        r_word    <= {r_hi, r_byte};
                        r_pending <= 1'b1;
                    end
                end
            end
            // Stale bytes from a previous run must not be taken as the word count.
            if (r_state == S_RESET_REL && w_next == S_RX_COUNT) begin
                r_phase   <= 1'b0;
                r_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rom_streamer.sv
// tb/tb_uart_rom_streamer.sv - self-checking bench for uart_rom_streamer
module tb_uart_rom_streamer;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n, run, uart_rx;
    logic        rom_loader_reset, rom_loader_load, rom_loader_ack, rom_loader_load_received;
    logic [15:0] rom_loader_data, words_loaded;
    logic        done_loading, busy, overrun_error, framing_error;

    uart_rom_streamer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .uart_rx(uart_rx),
        .rom_loader_reset(rom_loader_reset), .rom_loader_load(rom_loader_load),
        .rom_loader_data(rom_loader_data), .rom_loader_ack(rom_loader_ack),
        .rom_loader_load_received(rom_loader_load_received),
        .done_loading(done_loading), .busy(busy), .words_loaded(words_loaded),
        .overrun_error(overrun_error), .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    // SoC responder: acknowledge follows each request level a fixed number of cycles later.
    logic [255:0] hist_load = '0, hist_rst = '0;
    int           delay_load = 2;
    always @(posedge clk) begin
        hist_load <= {hist_load[254:0], rom_loader_load};
        hist_rst  <= {hist_rst[254:0], rom_loader_reset};
    end
    assign rom_loader_ack           = hist_rst[1];
    assign rom_loader_load_received = hist_load[delay_load-1];

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  tx_q[$];
    int          rst_edges = 0, overlap = 0, unstable = 0;
    logic        prev_load = 1'b0, prev_rst = 1'b0;
    logic [15:0] prev_data = '0;
    int          checks = 0, errors = 0;

    always @(posedge clk) begin
        #1;
        if (rom_loader_load && !prev_load) got_q.push_back(rom_loader_data);
        if (rom_loader_reset && !prev_rst) rst_edges++;
        if (rom_loader_load && rom_loader_reset) overlap++;
        if (rom_loader_load && prev_load && rom_loader_data !== prev_data) unstable++;
        prev_load = rom_loader_load;
        prev_rst  = rom_loader_reset;
        prev_data = rom_loader_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_q(input int max_gap);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], 1'b1);
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
    endtask

    // Reference: decode the host stream into the words that must be loaded, in order.
    task automatic model_decode();
        int n;
        exp_q.delete();
        n = (tx_q.size() >= 2) ? {tx_q[0], tx_q[1]} : 0;
        for (int k = 0; k < n && 3 + 2 * k < tx_q.size(); k++)
            exp_q.push_back({tx_q[2 + 2 * k], tx_q[3 + 2 * k]});
    endtask

    task automatic start_run();
        got_q.delete();
        rst_edges = 0;
        run = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (!done_loading && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", done_loading, 1);
    endtask

    task automatic end_run();
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_done", {done_loading, busy}, 0);
    endtask

    task automatic check_loads(input string tag);
        chk({tag, "_load_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[j])
            chk({tag, "_load_word"}, (j < got_q.size()) ? {16'h0, got_q[j]} : 32'hDEAD0000, exp_q[j]);
        chk({tag, "_words_loaded"}, words_loaded, exp_q.size());
        chk({tag, "_reset_hs"}, rst_edges, 1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (260) @(negedge clk);
        delay_load = 2;
    endtask

    typedef struct {
        logic [15:0]        n;
        logic [0:3][15:0]   w;
        int                 delay;
        int                 exp_loaded;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{n: 16'd2, w: {16'h1234, 16'hABCD, 16'h0, 16'h0}, delay: 2, exp_loaded: 2};
        tbl[1] = '{n: 16'd0, w: {16'h0, 16'h0, 16'h0, 16'h0}, delay: 2, exp_loaded: 0};
        tbl[2] = '{n: 16'd1, w: {16'hFFFF, 16'h0, 16'h0, 16'h0}, delay: 1, exp_loaded: 1};
        tbl[3] = '{n: 16'd4, w: {16'h0000, 16'h8001, 16'h7FFE, 16'h5A5A}, delay: 5, exp_loaded: 4};

        reset_n = 1'b0; run = 1'b0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {rom_loader_reset, rom_loader_load, done_loading, busy,
                            overrun_error, framing_error}, 0);
        chk("rst_data", rom_loader_data, 0);
        chk("rst_words", words_loaded, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            delay_load = tbl[i].delay;
            tx_q = '{tbl[i].n[15:8], tbl[i].n[7:0]};
            exp_q.delete();
            for (int k = 0; k < tbl[i].n; k++) begin
                tx_q.push_back(tbl[i].w[k][15:8]);
                tx_q.push_back(tbl[i].w[k][7:0]);
                if (k < tbl[i].exp_loaded) exp_q.push_back(tbl[i].w[k]);
            end
            start_run();
            send_q(0);
            wait_done(3000);
            check_loads("table");
            chk("table_errors", {overrun_error, framing_error}, 0);
            end_run();
        end

        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(6, 1);
            delay_load = $urandom_range(6, 1);
            tx_q = '{8'h00, 8'(n)};
            for (int k = 0; k < 2 * n; k++) tx_q.push_back(8'($urandom));
            model_decode();
            start_run();
            send_q(3);
            wait_done(4000);
            check_loads("random");
            chk("random_errors", {overrun_error, framing_error}, 0);
            end_run();
        end

        // Overrun: slow responder, three words sent back to back.
        delay_load = 200;
        tx_q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        start_run();
        send_q(0);
        repeat (1500) @(negedge clk);
        chk("ovr_flag", overrun_error, 1);
        chk("ovr_count", got_q.size(), 2);
        chk("ovr_word0", got_q.size() > 0 ? got_q[0] : 16'hDEAD, 16'h1122);
        chk("ovr_word1", got_q.size() > 1 ? got_q[1] : 16'hDEAD, 16'h3344);
        chk("ovr_words_loaded", words_loaded, 2);
        chk("ovr_waiting", {done_loading, busy}, 2'b01);
        pulse_reset();

        // Framing error, then valid bytes still assemble.
        start_run();
        send_byte(8'h55, 1'b0);
        tx_q = '{8'h00, 8'h01, 8'h12, 8'h34};
        exp_q = '{16'h1234};
        send_q(0);
        wait_done(2000);
        chk("frm_flag", framing_error, 1);
        check_loads("frm");
        end_run();

        // Glitches: one while idle, one while waiting for the count.
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_idle", {done_loading, busy}, 0);
        start_run();
        chk("frm_cleared", framing_error, 0);
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_rx", {done_loading, busy, framing_error}, 3'b010);
        chk("glitch_no_load", got_q.size(), 0);
        tx_q = '{8'h00, 8'h01, 8'hAB, 8'hCD};
        exp_q = '{16'hABCD};
        send_q(0);
        wait_done(2000);
        check_loads("glitch");
        end_run();

        // Async reset while load is requested.
        delay_load = 200;
        start_run();
        tx_q = '{8'h00, 8'h01, 8'h12, 8'h34};
        send_q(0);
        begin
            int k = 0;
            while (!rom_loader_load && k < 500) begin
                @(negedge clk);
                k++;
            end
        end
        chk("rst6_load_seen", rom_loader_load, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst6_load_drop", rom_loader_load, 0);
        chk("rst6_state", {busy, done_loading}, 0);
        chk("rst6_words", words_loaded, 0);
        run = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        repeat (260) @(negedge clk);

        chk("no_overlap", overlap, 0);
        chk("data_stable", unstable, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
